// File: rtl/tx_mac.sv
// Transmit Ethernet MAC: frames AXI-Stream payload bytes with preamble, SFD,
// zero padding to the minimum frame and CRC-32 FCS, then enforces the IFG.
module tx_mac #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_PAYLOAD    = 60,
  parameter int unsigned IFG_BYTES      = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_tx_axis_tdata,
  input  logic                  s_tx_axis_tvalid,
  input  logic                  s_tx_axis_tlast,
  output logic                  m_tx_axis_trdy,
  output logic [DATA_WIDTH-1:0] rgmii_mac_tx_data,
  output logic                  rgmii_mac_tx_en,
  output logic                  rgmii_mac_tx_er
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned SEQ_W   = 8;
  localparam int unsigned FCS_LEN = 4;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_PAYLOAD,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    en_q, en_d;
  logic                    er_q, er_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic [CNT_W-1:0]        pay_q, pay_d;
  logic [31:0]             crc_q, crc_d;

  logic [CNT_W:0]          pay_inc;
  logic [CNT_W-1:0]        pay_sat;
  logic [31:0]             fcs;
  logic [7:0]              fcs_byte;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign pay_inc  = {1'b0, pay_q} + (CNT_W+1)'(1);
  assign pay_sat  = (pay_q == {CNT_W{1'b1}}) ? pay_q : CNT_W'(pay_q + 1'b1);
  assign fcs      = ~crc_q;
  assign fcs_byte = 8'(fcs >> {seq_q[1:0], 3'b000});

  assign m_tx_axis_trdy    = (state_q == S_PAYLOAD);
  assign rgmii_mac_tx_data = data_q;
  assign rgmii_mac_tx_en   = en_q;
  assign rgmii_mac_tx_er   = er_q;

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      seq_q   <= '0;
      pay_q   <= '0;
      crc_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      er_q    <= er_d;
      seq_q   <= seq_d;
      pay_q   <= pay_d;
      crc_q   <= crc_d;
    end
  end

  // The state leads the registered byte by one cycle: each state computes
  // the byte that appears on the wire during the following cycle.
  always_comb begin
    state_d = state_q;
    data_d  = '0;
    en_d    = 1'b0;
    er_d    = 1'b0;
    seq_d   = seq_q;
    pay_d   = pay_q;
    crc_d   = crc_q;

    unique case (state_q)
      S_IDLE: begin
        if (s_tx_axis_tvalid) begin
          data_d  = PRE_BYTE;
          en_d    = 1'b1;
          seq_d   = SEQ_W'(1);
          state_d = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        data_d = PRE_BYTE;
        en_d   = 1'b1;
        seq_d  = SEQ_W'(seq_q + 1'b1);
        if (seq_q >= SEQ_W'(PREAMBLE_BYTES - 1)) state_d = S_SFD;
      end

      S_SFD: begin
        data_d  = SFD_BYTE;
        en_d    = 1'b1;
        crc_d   = 32'hFFFF_FFFF;
        pay_d   = '0;
        state_d = S_PAYLOAD;
      end

      S_PAYLOAD: begin
        en_d  = 1'b1;
        seq_d = '0;
        if (s_tx_axis_tvalid) begin
          data_d = s_tx_axis_tdata;
          crc_d  = crc_byte(crc_q, 8'(s_tx_axis_tdata));
          pay_d  = pay_sat;
          if (s_tx_axis_tlast) begin
            state_d = (pay_inc < (CNT_W+1)'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
          end
        end else begin
          // Store-and-forward source ran dry: abort with one error byte.
          er_d    = 1'b1;
          state_d = S_IFG;
        end
      end

      S_PAD: begin
        en_d  = 1'b1;
        crc_d = crc_byte(crc_q, 8'h00);
        pay_d = pay_sat;
        seq_d = '0;
        if (pay_inc >= (CNT_W+1)'(MIN_PAYLOAD)) state_d = S_FCS;
      end

      S_FCS: begin
        data_d = DATA_WIDTH'(fcs_byte);
        en_d   = 1'b1;
        seq_d  = SEQ_W'(seq_q + 1'b1);
        if (seq_q == SEQ_W'(FCS_LEN - 1)) begin
          seq_d   = '0;
          state_d = S_IFG;
        end
      end

      S_IFG: begin
        seq_d = SEQ_W'(seq_q + 1'b1);
        if (seq_q >= SEQ_W'(IFG_BYTES - 1)) begin
          seq_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_mac.sv
// Scoreboard bench for tx_mac: stimulus pushes expected wire bytes per frame,
// a negedge monitor pops and compares them along with run lengths and gaps.
module tb_tx_mac;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_tx_axis_tdata = '0;
  logic       s_tx_axis_tvalid = 1'b0;
  logic       s_tx_axis_tlast = 1'b0;
  logic       m_tx_axis_trdy;
  logic [7:0] rgmii_mac_tx_data;
  logic       rgmii_mac_tx_en;
  logic       rgmii_mac_tx_er;

  tx_mac dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .s_tx_axis_tdata   (s_tx_axis_tdata),
    .s_tx_axis_tvalid  (s_tx_axis_tvalid),
    .s_tx_axis_tlast   (s_tx_axis_tlast),
    .m_tx_axis_trdy    (m_tx_axis_trdy),
    .rgmii_mac_tx_data (rgmii_mac_tx_data),
    .rgmii_mac_tx_en   (rgmii_mac_tx_en),
    .rgmii_mac_tx_er   (rgmii_mac_tx_er)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Scoreboard: {tx_er, tx_data} per tx_en cycle, plus per-frame records.
  logic [8:0] exp_bytes[$];
  int         exp_len[$];
  int         exp_trdy[$];
  int         exp_gap[$];   // 12 = exact gap required, 0 = at least 12
  bit         mon_skip = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    checks++;
    $display("FAIL %s @%0t: bound expired", name, $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Reference CRC-32 in the non-reflected MSB-first form, bit-reversed at the end.
  function automatic logic [31:0] crc32(input byte_q_t m);
    logic [31:0] c;
    logic [31:0] r;
    logic        top;
    c = 32'hFFFF_FFFF;
    foreach (m[i]) begin
      for (int b = 0; b < 8; b++) begin
        top = c[31] ^ m[i][b];
        c   = c << 1;
        if (top) c = c ^ 32'h04C1_1DB7;
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  function automatic byte_q_t ramp(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic byte_q_t rnd_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic push_preamble();
    for (int i = 0; i < 7; i++) exp_bytes.push_back({1'b0, 8'h55});
    exp_bytes.push_back({1'b0, 8'hD5});
  endtask

  task automatic push_good(input byte_q_t pay, input int gap);
    byte_q_t     body;
    logic [31:0] c;
    body = pay;
    while (body.size() < 60) body.push_back(8'h00);
    c = crc32(body);
    exp_gap.push_back(gap);
    push_preamble();
    foreach (body[i]) exp_bytes.push_back({1'b0, body[i]});
    for (int i = 0; i < 4; i++) exp_bytes.push_back({1'b0, 8'(c >> (8 * i))});
    exp_len.push_back(8 + body.size() + 4);
    exp_trdy.push_back(pay.size());
  endtask

  task automatic push_underflow(input byte_q_t pay, input int gap);
    exp_gap.push_back(gap);
    push_preamble();
    foreach (pay[i]) exp_bytes.push_back({1'b0, pay[i]});
    exp_bytes.push_back({1'b1, 8'h00});
    exp_len.push_back(8 + pay.size() + 1);
    exp_trdy.push_back(pay.size() + 1);
  endtask

  // mode 0: full frame; 1: drop tvalid after pay (underflow); 2: reset after pay.
  task automatic send(input byte_q_t pay, input int mode, input int gap);
    int b;
    if (mode == 0) push_good(pay, gap);
    else if (mode == 1) push_underflow(pay, gap);
    else mon_skip = 1'b1;
    foreach (pay[i]) begin
      @(negedge clk);
      s_tx_axis_tvalid = 1'b1;
      s_tx_axis_tdata  = pay[i];
      s_tx_axis_tlast  = (mode == 0) && (i == pay.size() - 1);
      b = 0;
      while (!m_tx_axis_trdy) begin
        @(negedge clk);
        b++;
        if (b > 5000) abort_run("trdy_wait");
      end
    end
    if (mode != 0) begin
      @(negedge clk);
      s_tx_axis_tvalid = 1'b0;
      s_tx_axis_tlast  = 1'b0;
    end
    if (mode == 2) begin
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_en",   32'(rgmii_mac_tx_en), 0);
      check("rst_mid_er",   32'(rgmii_mac_tx_er), 0);
      check("rst_mid_data", 32'(rgmii_mac_tx_data), 0);
      check("rst_mid_trdy", 32'(m_tx_axis_trdy), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n  = 1'b1;
      mon_skip = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_tx_axis_tvalid = 1'b0;
    s_tx_axis_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_len.size() != 0) begin
      @(negedge clk);
      b++;
      if (b > 5000) abort_run("drain");
    end
    repeat (16) @(negedge clk);
  endtask

  // Monitor state
  bit         prev_en = 1'b0;
  bit         have_fall = 1'b0;
  int         run_len = 0;
  int         trdy_cnt = 0;
  int         gap_len = 0;
  int         gap_trdy = 0;
  int         gap_bad = 0;
  int         g;
  logic [8:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_skip) begin
        prev_en   = 1'b0;
        have_fall = 1'b0;
        gap_len   = 0;
        gap_trdy  = 0;
        gap_bad   = 0;
        continue;
      end
      if (rgmii_mac_tx_en) begin
        if (!prev_en) begin
          if (exp_gap.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            g = exp_gap.pop_front();
            if (have_fall) begin
              if (g > 0) check("ifg_exact", 32'(gap_len), 32'(g));
              else       check("ifg_min", 32'(gap_len >= 12), 1);
              check("gap_outputs_zero", 32'(gap_bad), 0);
              check("gap_trdy_low", 32'(gap_trdy), 0);
            end
          end
          run_len  = 0;
          trdy_cnt = 0;
        end
        run_len++;
        if (m_tx_axis_trdy) trdy_cnt++;
        if (exp_bytes.size() == 0) begin
          check("byte_overrun", 1, 0);
        end else begin
          e = exp_bytes.pop_front();
          check("wire_byte", 32'({rgmii_mac_tx_er, rgmii_mac_tx_data}), 32'(e));
        end
      end else begin
        if (prev_en) begin
          if (exp_len.size() == 0) begin
            check("unexpected_frame_end", 1, 0);
          end else begin
            check("tx_en_run_len", 32'(run_len), 32'(exp_len.pop_front()));
            check("trdy_cycles", 32'(trdy_cnt), 32'(exp_trdy.pop_front()));
          end
          gap_len   = 0;
          gap_trdy  = 0;
          gap_bad   = 0;
          have_fall = 1'b1;
        end
        gap_len++;
        if (m_tx_axis_trdy) gap_trdy++;
        if (rgmii_mac_tx_er || rgmii_mac_tx_data != 8'h00) gap_bad++;
      end
      prev_en = rgmii_mac_tx_en;
    end
  end

  initial begin
    #500000;
    abort_run("watchdog");
  end

  initial begin
    int n;
    bit b2b;
    #2;
    check("rst_en",   32'(rgmii_mac_tx_en), 0);
    check("rst_er",   32'(rgmii_mac_tx_er), 0);
    check("rst_data", 32'(rgmii_mac_tx_data), 0);
    check("rst_trdy", 32'(m_tx_axis_trdy), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    mon_skip = 1'b0;
    idle(3);

    send(ramp(64), 0, 0);
    idle(20);
    send(rnd_bytes(10), 0, 0);
    idle(5);
    send(rnd_bytes(60), 0, 0);
    send(rnd_bytes(61), 0, 12);
    send(rnd_bytes(21), 1, 12);
    send(rnd_bytes(33), 0, 12);

    for (int f = 0; f < 10; f++) begin
      n   = $urandom_range(1, 130);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) idle($urandom_range(0, 30));
      send(rnd_bytes(n), 0, b2b ? 12 : 0);
    end

    // Past the 11-bit counter limit; a wrapped count would wrongly pad.
    idle(4);
    send(rnd_bytes(2058), 0, 0);
    idle(2);
    drain();

    send(ramp(30), 2, 0);
    idle(3);
    send(ramp(64), 0, 0);
    send(rnd_bytes(5), 0, 12);

    idle(2);
    drain();
    check("leftover_bytes", 32'(exp_bytes.size()), 0);
    check("leftover_gaps",  32'(exp_gap.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
